// File: rtl/apb_requester.sv
// APB requester: turns a valid/ready command into one APB transfer and returns the
// result on a valid/ready response channel. A watchdog aborts transfers that the
// completer stalls for too long.
module apb_requester #(
    parameter int unsigned ADDR_W  = 12,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 16,
    parameter logic [2:0]  PROT    = 3'b000
) (
    input  logic                PCLK,
    input  logic                PRESET,
    // Command channel
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_write,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [DATA_W-1:0]   cmd_wdata,
    input  logic [DATA_W/8-1:0] cmd_strb,
    // Response channel
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err,
    output logic                rsp_timeout,
    // APB bus
    output logic                PSEL,
    output logic                PENABLE,
    output logic                PWRITE,
    output logic [ADDR_W-1:0]   PADDR,
    output logic [DATA_W-1:0]   PWDATA,
    output logic [DATA_W/8-1:0] PSTRB,
    output logic [2:0]          PPROT,
    input  logic                PREADY,
    input  logic [DATA_W-1:0]   PRDATA,
    input  logic                PSLVERR
);

    // Counter must be able to hold TIMEOUT; keep at least one bit when disabled.
    localparam int unsigned     CNT_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

    typedef enum logic [1:0] {
        StIdle,
        StSetup,
        StAccess,
        StResp
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] wait_cnt;
    logic             timeout_hit;

    // Last permitted wait cycle; only meaningful when the watchdog is enabled.
    assign timeout_hit = (TIMEOUT != 0) && (wait_cnt == CNT_LAST);

    assign PPROT = PROT;

    // Transfer FSM; every output is registered and updated on state transitions.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state       <= StIdle;
            wait_cnt    <= '0;
            cmd_ready   <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
            PSEL        <= 1'b0;
            PENABLE     <= 1'b0;
            PWRITE      <= 1'b0;
            PADDR       <= '0;
            PWDATA      <= '0;
            PSTRB       <= '0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (cmd_valid && cmd_ready) begin
                        // Bus address/data registers double as the command holding registers.
                        cmd_ready <= 1'b0;
                        PWRITE    <= cmd_write;
                        PADDR     <= cmd_addr;
                        PWDATA    <= cmd_wdata;
                        PSTRB     <= cmd_write ? cmd_strb : '0;
                        PSEL      <= 1'b1;
                        PENABLE   <= 1'b0;
                        state     <= StSetup;
                    end else begin
                        cmd_ready <= 1'b1;
                    end
                end
                StSetup: begin
                    PENABLE  <= 1'b1;
                    wait_cnt <= '0;
                    state    <= StAccess;
                end
                StAccess: begin
                    if (PREADY) begin
                        PSEL        <= 1'b0;
                        PENABLE     <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_rdata   <= PWRITE ? '0 : PRDATA;
                        rsp_err     <= PSLVERR;
                        rsp_timeout <= 1'b0;
                        state       <= StResp;
                    end else if (timeout_hit) begin
                        // Deliberate protocol abort: drop the bus mid-transfer.
                        PSEL        <= 1'b0;
                        PENABLE     <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_rdata   <= '0;
                        rsp_err     <= 1'b1;
                        rsp_timeout <= 1'b1;
                        state       <= StResp;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                StResp: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= StIdle;
                    end
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_requester.sv
// Self-checking bench for apb_requester: table of transfers driven through a
// completer model, responses checked from a scoreboard queue, plus hand-written
// reset and back-to-back sequences.
`timescale 1ns/1ps
module tb_apb_requester;

    localparam int unsigned ADDR_W  = 12;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned TIMEOUT = 4;
    localparam logic [2:0]  PROT    = 3'b010;

    logic        PCLK = 1'b0;
    logic        PRESET = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [11:0] cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic [3:0]  cmd_strb = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_timeout;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [11:0] PADDR;
    logic [31:0] PWDATA;
    logic [3:0]  PSTRB;
    logic [2:0]  PPROT;
    logic        PREADY = 1'b0;
    logic [31:0] PRDATA = '0;
    logic        PSLVERR = 1'b0;

    apb_requester #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .TIMEOUT(TIMEOUT),
        .PROT   (PROT)
    ) dut (
        .PCLK       (PCLK),
        .PRESET     (PRESET),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_write  (cmd_write),
        .cmd_addr   (cmd_addr),
        .cmd_wdata  (cmd_wdata),
        .cmd_strb   (cmd_strb),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .rsp_timeout(rsp_timeout),
        .PSEL       (PSEL),
        .PENABLE    (PENABLE),
        .PWRITE     (PWRITE),
        .PADDR      (PADDR),
        .PWDATA     (PWDATA),
        .PSTRB      (PSTRB),
        .PPROT      (PPROT),
        .PREADY     (PREADY),
        .PRDATA     (PRDATA),
        .PSLVERR    (PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    typedef struct {
        logic        write;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        int          waits;
        logic [31:0] prdata;
        logic        slverr;
        int          rsp_delay;
        logic [31:0] exp_rdata;
        logic        exp_err;
        logic        exp_to;
        int          lat;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        to;
        int          lat;
    } rsp_t;

    typedef struct {
        logic        write;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
    } apb_t;

    rsp_t scb[$];
    apb_t apbq[$];
    vec_t vecs[7];

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          hs_cyc = 0;
    int          cur_waits = 0;
    int          cur_rsp_delay = 0;
    logic [31:0] cur_prdata = '0;
    logic        cur_slverr = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic fail_evt(input string name);
        checks++;
        errors++;
        $display("FAIL %s: event seen=0 required=1", name);
    endtask

    always @(posedge PCLK) cyc <= cyc + 1;

    // Completer model: PREADY after cur_waits wait states of each ACCESS phase.
    int acc_cnt = 0;
    always @(negedge PCLK) begin
        if (PSEL && PENABLE) begin
            PREADY = (acc_cnt >= cur_waits);
            acc_cnt++;
        end else begin
            PREADY  = 1'b0;
            acc_cnt = 0;
        end
        PRDATA  = cur_prdata;
        PSLVERR = cur_slverr;
    end

    // APB protocol monitor: SETUP contents against expectations, ACCESS held stable.
    logic prev_sel = 1'b0;
    apb_t held;
    always @(negedge PCLK) begin
        if (PENABLE && !PSEL) fail_evt("penable_without_psel");
        if (PSEL && !PENABLE) begin
            if (apbq.size() == 0) begin
                fail_evt("expected_setup");
            end else begin
                held = apbq.pop_front();
                chk("setup_pwrite", 32'(PWRITE), 32'(held.write));
                chk("setup_paddr", 32'(PADDR), 32'(held.addr));
                if (held.write) chk("setup_pwdata", PWDATA, held.wdata);
                chk("setup_pstrb", 32'(PSTRB), 32'(held.strb));
            end
        end else if (PSEL && PENABLE) begin
            if (!prev_sel) fail_evt("setup_before_access");
            chk("access_paddr", 32'(PADDR), 32'(held.addr));
            chk("access_pwrite", 32'(PWRITE), 32'(held.write));
            if (held.write) chk("access_pwdata", PWDATA, held.wdata);
            chk("access_pstrb", 32'(PSTRB), 32'(held.strb));
        end
        prev_sel = PSEL;
    end

    // Response monitor: every rsp_valid cycle is compared with the scoreboard head.
    int vcnt = 0;
    always @(negedge PCLK) begin
        if (rsp_valid) begin
            if (scb.size() == 0) begin
                fail_evt("expected_rsp");
                rsp_ready = 1'b1;
            end else begin
                if (vcnt == 0) chk("rsp_latency", 32'(cyc - hs_cyc), 32'(scb[0].lat));
                chk("rsp_rdata", rsp_rdata, scb[0].rdata);
                chk("rsp_err", 32'(rsp_err), 32'(scb[0].err));
                chk("rsp_timeout", 32'(rsp_timeout), 32'(scb[0].to));
                chk("cmd_ready_in_resp", 32'(cmd_ready), 32'd0);
                if (vcnt >= cur_rsp_delay) begin
                    rsp_ready = 1'b1;
                    scb.delete(0);
                end else begin
                    rsp_ready = 1'b0;
                end
            end
            vcnt++;
        end else begin
            vcnt      = 0;
            rsp_ready = 1'b0;
        end
    end

    // Call at a negedge with cmd_valid already driven.
    task automatic wait_hs();
        int n = 0;
        while (!cmd_ready && n < 20) begin
            @(negedge PCLK);
            n++;
        end
        if (!cmd_ready) fail_evt("cmd_handshake");
        else hs_cyc = cyc;
    endtask

    task automatic wait_rsp_drain();
        int n = 0;
        while (scb.size() != 0 && n < 100) begin
            @(negedge PCLK);
            n++;
        end
        if (scb.size() != 0) begin
            fail_evt("rsp_drain");
            scb.delete();
        end
        @(negedge PCLK);
    endtask

    task automatic send(input vec_t v);
        cur_waits     = v.waits;
        cur_prdata    = v.prdata;
        cur_slverr    = v.slverr;
        cur_rsp_delay = v.rsp_delay;
        apbq.push_back('{v.write, v.addr, v.wdata, v.write ? v.strb : 4'h0});
        scb.push_back('{v.exp_rdata, v.exp_err, v.exp_to, v.lat});
        cmd_valid = 1'b1;
        cmd_write = v.write;
        cmd_addr  = v.addr;
        cmd_wdata = v.wdata;
        cmd_strb  = v.strb;
        wait_hs();
        @(posedge PCLK);
        #1 cmd_valid = 1'b0;
        wait_rsp_drain();
    endtask

    initial begin
        #200000;
        $display("FAIL global_watchdog: finished=0 required=1");
        $fatal(1);
    end

    initial begin
        int prev_hs;

        //        wr     addr     wdata         strb  wt  prdata        err   dly rdata         eerr  eto   lat
        vecs[0] = '{1'b1, 12'h010, 32'hDEADBEEF, 4'hF, 0,   32'h00000000, 1'b0, 0, 32'h00000000, 1'b0, 1'b0, 3};
        vecs[1] = '{1'b0, 12'h024, 32'h5555AAAA, 4'hF, 3,   32'h12345678, 1'b0, 0, 32'h12345678, 1'b0, 1'b0, 6};
        vecs[2] = '{1'b1, 12'h100, 32'hA5A50001, 4'h3, 0,   32'hFFFF0000, 1'b1, 5, 32'h00000000, 1'b1, 1'b0, 3};
        vecs[3] = '{1'b0, 12'h200, 32'h00000000, 4'hF, 100, 32'hCAFEF00D, 1'b0, 0, 32'h00000000, 1'b1, 1'b1, 6};
        vecs[4] = '{1'b0, 12'h204, 32'h00000000, 4'h0, 3,   32'h0BADC0DE, 1'b0, 0, 32'h0BADC0DE, 1'b0, 1'b0, 6};
        vecs[5] = '{1'b0, 12'h2FC, 32'h00000000, 4'hA, 1,   32'h11112222, 1'b1, 0, 32'h11112222, 1'b1, 1'b0, 4};
        vecs[6] = '{1'b1, 12'hFFC, 32'h01020304, 4'h5, 2,   32'h99999999, 1'b0, 2, 32'h00000000, 1'b0, 1'b0, 5};

        // Reset state
        repeat (3) @(negedge PCLK);
        chk("rst_psel", 32'(PSEL), 32'd0);
        chk("rst_penable", 32'(PENABLE), 32'd0);
        chk("rst_pwrite", 32'(PWRITE), 32'd0);
        chk("rst_paddr", 32'(PADDR), 32'd0);
        chk("rst_pwdata", PWDATA, 32'd0);
        chk("rst_pstrb", 32'(PSTRB), 32'd0);
        chk("rst_pprot", 32'(PPROT), 32'(PROT));
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        chk("rst_rsp_timeout", 32'(rsp_timeout), 32'd0);
        PRESET = 1'b0;
        @(negedge PCLK);
        chk("cmd_ready_after_reset", 32'(cmd_ready), 32'd1);

        // Table-driven transfers
        for (int i = 0; i < 7; i++) send(vecs[i]);
        chk("pprot_const", 32'(PPROT), 32'(PROT));
        chk("paddr_kept_after_xfer", 32'(PADDR), 32'h0FFC);
        chk("psel_idle", 32'(PSEL), 32'd0);

        // Reset during an ACCESS wait state
        cur_waits     = 100;
        cur_slverr    = 1'b0;
        cur_rsp_delay = 0;
        apbq.push_back('{1'b0, 12'h3F0, 32'h0, 4'h0});
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 12'h3F0;
        cmd_strb  = 4'hF;
        wait_hs();
        @(posedge PCLK);
        #1 cmd_valid = 1'b0;
        @(negedge PCLK);
        @(negedge PCLK);
        chk("mid_penable_before_rst", 32'(PENABLE), 32'd1);
        PRESET = 1'b1;
        @(negedge PCLK);
        chk("mid_rst_psel", 32'(PSEL), 32'd0);
        chk("mid_rst_penable", 32'(PENABLE), 32'd0);
        chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("mid_rst_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("mid_rst_paddr", 32'(PADDR), 32'd0);
        PRESET = 1'b0;
        @(negedge PCLK);
        chk("mid_rst_cmd_ready_after", 32'(cmd_ready), 32'd1);
        repeat (8) @(negedge PCLK);
        chk("mid_rst_apbq_empty", 32'(apbq.size()), 32'd0);

        // Back-to-back with cmd_valid held
        cur_waits     = 0;
        cur_prdata    = 32'h77777777;
        cur_rsp_delay = 0;
        for (int i = 0; i < 3; i++) begin
            apbq.push_back('{1'b1, 12'(12'h040 + 4 * i), 32'(32'hB0B0_0000 + i), 4'hF});
            scb.push_back('{32'h0, 1'b0, 1'b0, 3});
        end
        prev_hs = 0;
        for (int i = 0; i < 3; i++) begin
            cmd_valid = 1'b1;
            cmd_write = 1'b1;
            cmd_addr  = 12'(12'h040 + 4 * i);
            cmd_wdata = 32'(32'hB0B0_0000 + i);
            cmd_strb  = 4'hF;
            wait_hs();
            if (i > 0) chk("b2b_spacing", 32'(hs_cyc - prev_hs), 32'd4);
            prev_hs = hs_cyc;
            @(posedge PCLK);
            #1;
        end
        cmd_valid = 1'b0;
        wait_rsp_drain();
        chk("b2b_apbq_empty", 32'(apbq.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
